// File: rtl/io_pkg.sv
// Shared definitions for the I/O port controller.
//   ADDR_*      : register map seen by the load/store unit
//   io_state_t  : controller FSM state encoding
package io_pkg;

  localparam logic [1:0] ADDR_DIR  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_PIN  = 2'd2;
  localparam logic [1:0] ADDR_CHG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } io_state_t;

endpackage

// File: rtl/io_sync.sv
// Enabled shift-register synchronizer for the port pin read path.
//   CLK  in  clock
//   RST  in  synchronous active-high reset (clears every stage)
//   en   in  shift enable; stages hold when low so undriven pins are never sampled
//   d    in  WIDTH  raw pin data
//   q    out WIDTH  last stage
module io_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_ctrl.sv
// Bus-side controller for the 8-bit I/O port subsystem.
// Converts REQ/ACK transactions into direction/data register strobes and
// timed read-buffer windows, keeps shadow copies and a sticky change flag.
//   CLK, RST         clock / synchronous active-high reset
//   REQ, WE, ADDR    request, write flag, register address
//   WDATA, RDATA     write data / read data (held between ACKs)
//   ACK, BUSY        completion pulse / FSM not idle
//   PDR_EN, PDR_DATA direction-register strobe and value
//   PORT_EN, PORT_DATA data-register strobe and value
//   PORT_RD, PORT_READ_DATA read-buffer enable and its output
//
// state      | meaning
// ST_IDLE    | waiting for REQ; latches WE/ADDR/WDATA
// ST_EXEC    | decode; register writes issue their strobe here
// ST_RD_WAIT | PORT_RD window, synchronizer shifting
// ST_DONE    | ACK and RDATA issued on the closing edge
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             WE,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic             ACK,
  output logic [WIDTH-1:0] RDATA,
  output logic             BUSY,
  output logic             PDR_EN,
  output logic             PDR_DATA,
  output logic             PORT_EN,
  output logic [WIDTH-1:0] PORT_DATA,
  output logic             PORT_RD,
  input  logic [WIDTH-1:0] PORT_READ_DATA
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  io_state_t        state, state_next;
  logic             we_q;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] last_pin;
  logic             change;
  logic [WIDTH-1:0] sync_q;
  logic             pdr_en_next, port_en_next, ack_next;

  io_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .en  (PORT_RD),
    .d   (PORT_READ_DATA),
    .q   (sync_q)
  );

  assign BUSY    = (state != ST_IDLE);
  assign PORT_RD = (state == ST_RD_WAIT);

  always_comb begin
    state_next   = state;
    pdr_en_next  = 1'b0;
    port_en_next = 1'b0;
    ack_next     = 1'b0;
    case (state)
      ST_IDLE: if (REQ) state_next = ST_EXEC;
      ST_EXEC: begin
        if (we_q) begin
          pdr_en_next  = (addr_q == ADDR_DIR);
          port_en_next = (addr_q == ADDR_DATA);
          state_next   = ST_DONE;
        end else if (addr_q == ADDR_PIN) begin
          state_next = ST_RD_WAIT;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_RD_WAIT: if (cnt == CNT_W'(1)) state_next = ST_DONE;
      ST_DONE: begin
        ack_next   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      PDR_EN    <= 1'b0;
      PORT_EN   <= 1'b0;
      ACK       <= 1'b0;
      PDR_DATA  <= 1'b0;
      PORT_DATA <= '0;
      RDATA     <= '0;
      last_pin  <= '0;
      change    <= 1'b0;
    end else begin
      state   <= state_next;
      PDR_EN  <= pdr_en_next;
      PORT_EN <= port_en_next;
      ACK     <= ack_next;

      if (state == ST_IDLE && REQ) begin
        we_q    <= WE;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
      end

      if (state_next == ST_RD_WAIT && state == ST_EXEC) cnt <= CNT_W'(SYNC_STAGES);
      else if (state == ST_RD_WAIT)                     cnt <= cnt - CNT_W'(1);

      // Shadows move on the same edge as the strobe so both appear together.
      if (pdr_en_next)  PDR_DATA  <= wdata_q[0];
      if (port_en_next) PORT_DATA <= wdata_q;

      // The window is over by DONE, so the synchronizer output is complete and frozen.
      if (state == ST_DONE && !we_q) begin
        case (addr_q)
          ADDR_DIR:  RDATA <= WIDTH'(PDR_DATA);
          ADDR_DATA: RDATA <= PORT_DATA;
          ADDR_PIN: begin
            RDATA    <= sync_q;
            last_pin <= sync_q;
            if (!PDR_DATA && (sync_q != last_pin)) change <= 1'b1;
          end
          default: begin
            RDATA  <= WIDTH'(change);
            change <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

  localparam int W = 8;
  localparam int S = 2;

  logic         CLK, RST, REQ, WE;
  logic [1:0]   ADDR;
  logic [W-1:0] WDATA, RDATA, PORT_DATA, PORT_READ_DATA;
  logic         ACK, BUSY, PDR_EN, PDR_DATA, PORT_EN, PORT_RD;

  io_port_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .PDR_EN(PDR_EN), .PDR_DATA(PDR_DATA),
    .PORT_EN(PORT_EN), .PORT_DATA(PORT_DATA), .PORT_RD(PORT_RD),
    .PORT_READ_DATA(PORT_READ_DATA)
  );

  typedef struct {
    int           ack_cyc;
    bit           chk_rd;
    logic [W-1:0] rdata;
    bit           pin;
    logic         dir;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    int           cyc;
    bit           is_pdr;
    logic [W-1:0] val;
  } stb_t;

  exp_t sb[$];
  stb_t sq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pr_cnt = 0;
  logic [W-1:0] pin_val = '0;

  // Reference model: architectural register contents
  logic         m_dir = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_last = '0;
  logic         m_chg = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Read buffer only carries pin data while enabled; otherwise junk.
  initial begin
    PORT_READ_DATA = '0;
    forever begin
      @(negedge CLK);
      PORT_READ_DATA = PORT_RD ? pin_val : W'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or ACK.
  initial begin
    exp_t e;
    stb_t s;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pr_cnt = 0;
      end else begin
        if (PORT_RD) pr_cnt++;
        if (PDR_EN) begin
          if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL pdr_en_unexpected: got strobe expected none (cycle %0d)", cyc);
          end else begin
            s = sq.pop_front();
            chk("pdr_en_cycle", cyc, s.cyc);
            chk("pdr_en_kind", 32'(PDR_EN), 32'(s.is_pdr));
            chk("pdr_data_at_strobe", 32'(PDR_DATA), 32'(s.val[0]));
          end
        end
        if (PORT_EN) begin
          if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL port_en_unexpected: got strobe expected none (cycle %0d)", cyc);
          end else begin
            s = sq.pop_front();
            chk("port_en_cycle", cyc, s.cyc);
            chk("port_en_kind", 32'(PORT_EN), 32'(!s.is_pdr));
            chk("port_data_at_strobe", 32'(PORT_DATA), 32'(s.val));
          end
        end
        if (ACK) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack_unexpected: got ACK expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_cycle", cyc, e.ack_cyc);
            if (e.chk_rd) chk("rdata", 32'(RDATA), 32'(e.rdata));
            chk("port_rd_cycles", pr_cnt, e.pin ? S : 0);
            chk("pdr_data_shadow", 32'(PDR_DATA), 32'(e.dir));
            chk("port_data_shadow", 32'(PORT_DATA), 32'(e.data));
            chk("busy_at_ack", 32'(BUSY), 0);
          end
          pr_cnt = 0;
        end
      end
    end
  end

  // Issue one transaction from a negedge; returns at the ACK-cycle negedge.
  task automatic do_txn(input logic we, input logic [1:0] addr, input logic [W-1:0] wd,
                        input logic [W-1:0] pins, input bit hold);
    exp_t e;
    stb_t s;
    int t;
    bit got;
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wd; pin_val = pins;
    t = cyc + 1;
    e.chk_rd = !we;
    e.pin    = (!we && addr == 2'd2);
    e.rdata  = '0;
    if (we) begin
      if (addr == 2'd0) begin
        m_dir = wd[0];
        s.cyc = t + 1; s.is_pdr = 1'b1; s.val = W'(wd[0]);
        sq.push_back(s);
      end else if (addr == 2'd1) begin
        m_data = wd;
        s.cyc = t + 1; s.is_pdr = 1'b0; s.val = wd;
        sq.push_back(s);
      end
    end else begin
      case (addr)
        2'd0: e.rdata = W'(m_dir);
        2'd1: e.rdata = m_data;
        2'd2: begin
          e.rdata = pins;
          if (!m_dir && pins != m_last) m_chg = 1'b1;
          m_last = pins;
        end
        default: begin
          e.rdata = W'(m_chg);
          m_chg = 1'b0;
        end
      endcase
    end
    e.ack_cyc = t + (e.pin ? 2 + S : 2);
    e.dir     = m_dir;
    e.data    = m_data;
    sb.push_back(e);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge CLK);
      if (ACK) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ACK expected one by cycle %0d", cyc);
    end
    if (!hold) REQ = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [1:0] addr, input logic [W-1:0] wd,
                     input logic [W-1:0] pins);
    do_txn(we, addr, wd, pins, 1'b0);
    repeat ($urandom_range(1, 3)) @(negedge CLK);
  endtask

  initial begin
    REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0; RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    chk("rst_pdr", 32'({PDR_EN, PDR_DATA}), 0);
    chk("rst_port", 32'({PORT_EN, PORT_DATA}), 0);
    chk("rst_port_rd", 32'(PORT_RD), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Abort a PIN read with a two-cycle reset inside the read window.
    REQ = 1'b1; WE = 1'b0; ADDR = 2'd2; pin_val = 8'hC3;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    chk("abort_in_window", 32'(PORT_RD), 1);
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("abort_ack", 32'(ACK), 0);
      chk("abort_strobes", 32'({PDR_EN, PORT_EN}), 0);
      chk("abort_outputs", 32'({BUSY, PORT_RD, PDR_DATA}), 0);
      chk("abort_port_data", 32'(PORT_DATA), 0);
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", 32'(BUSY), 0);
    chk("post_rst_ack", 32'(ACK), 0);
    @(negedge CLK);

    // Direction / data writes and a PIN read
    txn(1'b1, 2'd0, 8'h01, 8'h00);
    txn(1'b1, 2'd1, 8'hAA, 8'h00);
    txn(1'b0, 2'd0, 8'h00, 8'h00);
    txn(1'b0, 2'd1, 8'h00, 8'h00);
    txn(1'b0, 2'd2, 8'h00, 8'h5A);

    // Change flag with pins as inputs, then as outputs
    txn(1'b1, 2'd0, 8'h00, 8'h00);
    txn(1'b0, 2'd2, 8'h00, 8'h5A);
    txn(1'b0, 2'd2, 8'h00, 8'h5B);
    txn(1'b0, 2'd3, 8'h00, 8'h00);
    txn(1'b0, 2'd3, 8'h00, 8'h00);
    txn(1'b1, 2'd0, 8'h01, 8'h00);
    txn(1'b0, 2'd2, 8'h00, 8'h5A);
    txn(1'b0, 2'd2, 8'h00, 8'h5B);
    txn(1'b0, 2'd3, 8'h00, 8'h00);
    txn(1'b0, 2'd3, 8'h00, 8'h00);

    // Reserved writes leave the shadows alone
    txn(1'b1, 2'd2, 8'hFF, 8'h00);
    txn(1'b1, 2'd3, 8'hFF, 8'h00);
    txn(1'b0, 2'd0, 8'h00, 8'h00);
    txn(1'b0, 2'd1, 8'h00, 8'h00);

    // Back-to-back with REQ held through ACK
    do_txn(1'b1, 2'd1, 8'h33, 8'h00, 1'b1);
    do_txn(1'b0, 2'd1, 8'h00, 8'h00, 1'b1);
    do_txn(1'b0, 2'd2, 8'h00, 8'h77, 1'b1);
    txn(1'b0, 2'd0, 8'h00, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [W-1:0] pins;
      bit hold;
      pins = ($urandom_range(0, 2) == 0) ? m_last : W'($urandom);
      hold = (n != 79) && ($urandom_range(0, 3) == 0);
      if (hold) do_txn(1'($urandom), 2'($urandom), W'($urandom), pins, 1'b1);
      else      txn(1'($urandom), 2'($urandom), W'($urandom), pins);
    end

    repeat (6) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    chk("strobes_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
